// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller sequencing a shift-right deserializer.
// Build with UART_RX_MAJORITY_EN defined for 2-of-3 majority sampling per bit.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic [PRESC_W-1:0] Prescale,
  output logic               deser_en,
  output logic               sampled_bit,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             state_q;
  logic               rx_meta_q;
  logic               rx_sync_q;
  logic               rx_prev_q;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] edge_q;
  logic [BW-1:0]      bit_cnt_q;
  logic               par_run_q;
  logic               par_fail_q;
  logic               deser_en_q;
  logic               sampled_bit_q;
  logic               data_valid_q;
  logic               par_err_q;
  logic               stp_err_q;

  logic [PRESC_W-1:0] half;
  logic               last_edge;
  logic               decide;
  logic               bit_d;

  assign half      = presc_q >> 1;
  assign last_edge = (edge_q == presc_q - 1'b1);
  assign decide    = (edge_q == half + PRESC_W'(2));

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] cap_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap_q <= '0;
    end else if (state_q != IDLE) begin
      if (edge_q == half - 1'b1) cap_q[0] <= rx_sync_q;
      if (edge_q == half)        cap_q[1] <= rx_sync_q;
      if (edge_q == half + 1'b1) cap_q[2] <= rx_sync_q;
    end
  end

  assign bit_d = (cap_q[0] & cap_q[1]) |
                 (cap_q[0] & cap_q[2]) |
                 (cap_q[1] & cap_q[2]);
`else
  logic cap_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap_q <= 1'b0;
    end else if (state_q != IDLE && edge_q == half) begin
      cap_q <= rx_sync_q;
    end
  end

  assign bit_d = cap_q;
`endif

  // Sync flops reset low so a line already low at reset never looks like a start edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      rx_meta_q     <= 1'b0;
      rx_sync_q     <= 1'b0;
      rx_prev_q     <= 1'b0;
      presc_q       <= '0;
      edge_q        <= '0;
      bit_cnt_q     <= '0;
      par_run_q     <= 1'b0;
      par_fail_q    <= 1'b0;
      deser_en_q    <= 1'b0;
      sampled_bit_q <= 1'b0;
      data_valid_q  <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
    end else begin
      rx_meta_q    <= RX_IN;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      deser_en_q   <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      if (state_q != IDLE) edge_q <= last_edge ? '0 : edge_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q    <= START;
            edge_q     <= '0;
            presc_q    <= Prescale;
            par_run_q  <= 1'b0;
            par_fail_q <= 1'b0;
          end
        end
        START: begin
          if (decide && bit_d) begin
            state_q <= IDLE;
          end else if (last_edge) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (decide) begin
            deser_en_q    <= 1'b1;
            sampled_bit_q <= bit_d;
            par_run_q     <= par_run_q ^ bit_d;
          end
          if (last_edge) begin
            if (bit_cnt_q == BW'(DATA_WIDTH - 1))
              state_q <= PAR_EN ? PARITY : STOP;
            else
              bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (decide) par_fail_q <= (bit_d != (par_run_q ^ PAR_TYP));
          if (last_edge) state_q <= STOP;
        end
        STOP: begin
          if (decide) begin
            state_q      <= IDLE;
            stp_err_q    <= !bit_d;
            par_err_q    <= bit_d && par_fail_q;
            data_valid_q <= bit_d && !par_fail_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign deser_en    = deser_en_q;
  assign sampled_bit = sampled_bit_q;
  assign data_valid  = data_valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and random frames against a frame-level reference model.
// The spike test expectation follows UART_RX_MAJORITY_EN.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] presc = 6'd8;
  logic       deser_en, sampled_bit, data_valid, par_err, stp_err, busy;

  int n_assert = 0;
  int n_fail = 0;
  int n_deser, n_dv, n_pe, n_se, n_busy;
  logic [7:0] p_data = 8'h00;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .CLK(clk), .RST(rst), .RX_IN(rx), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .Prescale(presc), .deser_en(deser_en), .sampled_bit(sampled_bit),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  // Deserializer model plus pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (deser_en) begin
        n_deser = n_deser + 1;
        p_data = {sampled_bit, p_data[7:1]};
      end
      if (data_valid) n_dv = n_dv + 1;
      if (par_err) n_pe = n_pe + 1;
      if (stp_err) n_se = n_se + 1;
      if (busy) n_busy = n_busy + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cnt();
    n_deser = 0; n_dv = 0; n_pe = 0; n_se = 0; n_busy = 0;
  endtask

  // Drive one frame bit by bit; optional inverted spike or reset mid-frame.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pen,
                            input bit ptyp, input bit pbit, input bit stop,
                            input int spike_bit, input int rst_bit, input int gap);
    logic fb [$];
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(d[i]);
    if (pen) fb.push_back(pbit);
    fb.push_back(stop);
    presc = 6'(p);
    par_en = pen;
    par_typ = ptyp;
    for (int i = 0; i < fb.size(); i++) begin
      for (int c = 0; c < p; c++) begin
        if (i == rst_bit && c == p / 2) begin
          rst = 1'b1;
          rx = 1'b1;
          return;
        end
        rx = (i == spike_bit && c == p / 2 + 1) ? ~fb[i] : fb[i];
        tick();
      end
    end
    rx = 1'b1;
    repeat (gap) tick();
  endtask

  // Frame-level reference: stop error first, then parity by ones count, else valid.
  task automatic check_frame(input string tag, input logic [7:0] d, input bit pen,
                             input bit ptyp, input bit pbit, input bit stop);
    int ones;
    bit par_ok;
    ones = $countones(d) + int'(pbit);
    par_ok = !pen || (ptyp ? (ones % 2 == 1) : (ones % 2 == 0));
    chk({tag, ".deser"}, n_deser, 8);
    chk({tag, ".pdata"}, int'(p_data), int'(d));
    chk({tag, ".stp"}, n_se, int'(!stop));
    chk({tag, ".par"}, n_pe, int'(stop && !par_ok));
    chk({tag, ".dv"}, n_dv, int'(stop && par_ok));
  endtask

  function automatic bit even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  initial begin
    logic [7:0] rd, exp_spk;
    int rp;
    bit rpen, rtyp, rpb, rstop;

    clear_cnt();
    repeat (3) tick();
    @(negedge clk);
    chk("reset.outs", int'({deser_en, sampled_bit, data_valid, par_err, stp_err, busy}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("reset.idle", int'({deser_en, data_valid, par_err, stp_err, busy}), 0);
    tick();

    clear_cnt();
    send_frame(8'hA5, 8, 0, 0, 0, 1, -1, -1, 12);
    check_frame("t1", 8'hA5, 0, 0, 0, 1);

    clear_cnt();
    send_frame(8'h3C, 16, 1, 0, 1, 1, -1, -1, 20);
    check_frame("t2", 8'h3C, 1, 0, 1, 1);

    clear_cnt();
    send_frame(8'hFF, 32, 0, 0, 0, 0, -1, -1, 0);
    rx = 1'b0;
    check_frame("t3", 8'hFF, 0, 0, 0, 0);
    n_busy = 0;
    repeat (100) tick();
    chk("t3.stuck_busy", n_busy, 0);
    rx = 1'b1;
    repeat (20) tick();

    clear_cnt();
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (30) tick();
    chk("t4.busy_seen", int'(n_busy > 0), 1);
    chk("t4.busy_now", int'(busy), 0);
    chk("t4.deser", n_deser, 0);
    chk("t4.flags", n_dv + n_pe + n_se, 0);

    clear_cnt();
    send_frame(8'h01, 8, 1, 1, !even_par(8'h01), 1, -1, -1, 0);
    send_frame(8'h80, 8, 1, 1, !even_par(8'h80), 1, -1, -1, 12);
    chk("t5.deser", n_deser, 16);
    chk("t5.dv", n_dv, 2);
    chk("t5.errs", n_pe + n_se, 0);
    chk("t5.pdata", int'(p_data), 32'h80);

    clear_cnt();
    send_frame(8'hC3, 16, 0, 0, 0, 1, -1, 5, 0);
    @(negedge clk);
    chk("t6.rst_outs", int'({deser_en, data_valid, par_err, stp_err, busy}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) tick();
    clear_cnt();
    send_frame(8'h55, 16, 0, 0, 0, 1, -1, -1, 20);
    check_frame("t6", 8'h55, 0, 0, 0, 1);

`ifdef UART_RX_MAJORITY_EN
    exp_spk = 8'h55;
`else
    exp_spk = 8'h55 ^ 8'h04;
`endif
    clear_cnt();
    send_frame(8'h55, 8, 0, 0, 0, 1, 3, -1, 12);
    chk("spike.deser", n_deser, 8);
    chk("spike.pdata", int'(p_data), int'(exp_spk));
    chk("spike.dv", n_dv, 1);

    for (int k = 0; k < 12; k++) begin
      rd = 8'($urandom);
      rp = 8 << $urandom_range(0, 2);
      rpen = 1'($urandom);
      rtyp = 1'($urandom);
      rpb = 1'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      clear_cnt();
      send_frame(rd, rp, rpen, rtyp, rpb, rstop, -1, -1, rp + 4);
      check_frame($sformatf("rnd%0d", k), rd, rpen, rtyp, rpb, rstop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
